// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_BUF = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
  function automatic fwd_sel_t fwd_pick(
    input logic [4:0] src,
    input logic       mem_wr,
    input logic [4:0] mem_rd,
    input logic       wb_wr,
    input logic [4:0] wb_rd
  );
    if (mem_wr && mem_rd != REG_ZERO && mem_rd == src) return FWD_MEM;
    if (wb_wr && wb_rd != REG_ZERO && wb_rd == src)    return FWD_WB;
    return FWD_BUF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the ID-EX-MEM-WB pipeline,
// with a small FSM for memory waits and multi-cycle branch flushes.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic             br_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_wr,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_wr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_if,
  output logic             flush_id,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic       frozen, branch, load_use;

  assign frozen = mem_req & ~mem_ready;
  assign branch = ex_valid & br_taken & ~frozen;
  assign load_use = ex_valid & ex_is_load & (ex_rd != REG_ZERO) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    if (rst) begin
      state_nxt = RUN;
      fcnt_nxt  = '0;
    end else if (frozen) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      state_nxt = MEM_WAIT;
    end else if (branch) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        fcnt_nxt  = FLUSH_RELOAD;
      end else begin
        state_nxt = RUN;
      end
    end else if (state == FLUSH) begin
      // ID holds a killed instruction here, so load-use is not evaluated.
      flush_if = 1'b1;
      if (fcnt <= 3'd1) begin
        state_nxt = RUN;
        fcnt_nxt  = '0;
      end else begin
        fcnt_nxt = fcnt - 3'd1;
      end
    end else begin
      state_nxt = RUN;
      if (load_use) begin
        stall_if = 1'b1;
        flush_id = 1'b1;
      end
    end
  end

  assign fwd_a_sel = rst ? FWD_BUF : fwd_pick(ex_rs1, mem_reg_wr, mem_rd, wb_reg_wr, wb_rd);
  assign fwd_b_sel = rst ? FWD_BUF : fwd_pick(ex_rs2, mem_reg_wr, mem_rd, wb_reg_wr, wb_rd);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_if),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_if),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks for hazard_ctrl; a narrow-counter instance covers saturation.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_valid, ex_is_load, br_taken;
  logic        mem_reg_wr, mem_req, mem_ready, wb_reg_wr;
  logic        stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cnt, flush_cnt;

  logic        n_stall_if, n_stall_id, n_stall_ex, n_stall_mem, n_flush_if, n_flush_id;
  logic [1:0]  n_fwd_a_sel, n_fwd_b_sel;
  logic [2:0]  n_stall_cnt, n_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .br_taken(br_taken),
    .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_if(flush_if), .flush_id(flush_id),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(3)) dut_narrow (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .br_taken(br_taken),
    .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
    .stall_if(n_stall_if), .stall_id(n_stall_id), .stall_ex(n_stall_ex), .stall_mem(n_stall_mem),
    .flush_if(n_flush_if), .flush_id(n_flush_id),
    .fwd_a_sel(n_fwd_a_sel), .fwd_b_sel(n_fwd_b_sel),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_rs1 = '0; ex_rs2 = '0;
    br_taken = 1'b0; mem_rd = '0; mem_reg_wr = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    wb_rd = '0; wb_reg_wr = 1'b0;
  endtask

  task automatic check_stalls(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, stall_if, stall_id, stall_ex, stall_mem}, {28'd0, exp});
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();

    // Outputs are forced low while reset is held, even with hazards present.
    ex_valid = 1'b1; br_taken = 1'b1; mem_req = 1'b1;
    mem_rd = 5'd3; mem_reg_wr = 1'b1; ex_rs1 = 5'd3;
    @(negedge clk);
    check_stalls("rst_stalls", 4'b0000);
    check("rst_flush", {30'd0, flush_if, flush_id}, 32'd0);
    check("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_state", 32'(dut.state), 32'(RUN));
    tick();
    idle();
    rst = 1'b0;
    tick();

    // Load-use on x5: one bubble, then WB forwarding to the consumer.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    @(negedge clk);
    check_stalls("lu_stalls", 4'b1000);
    check("lu_flush_id", 32'(flush_id), 32'd1);
    check("lu_flush_if", 32'(flush_if), 32'd0);
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0; mem_rd = 5'd5; mem_reg_wr = 1'b1;
    @(negedge clk);
    check("lu_bubble_stall_if", 32'(stall_if), 32'd0);
    check("lu_bubble_flush_id", 32'(flush_id), 32'd0);
    check("lu_stall_cnt", stall_cnt, 32'd1);
    tick();
    ex_valid = 1'b1; ex_rd = 5'd9; ex_rs1 = 5'd5; id_use_rs1 = 1'b0;
    mem_reg_wr = 1'b0; wb_rd = 5'd5; wb_reg_wr = 1'b1;
    @(negedge clk);
    check("lu_fwd_a_wb", 32'(fwd_a_sel), 32'(FWD_WB));
    check("lu_fwd_b_buf", 32'(fwd_b_sel), 32'(FWD_BUF));
    tick();
    idle();

    // Load targeting x0 is not a hazard and x0 is never forwarded.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    mem_rd = 5'd0; mem_reg_wr = 1'b1; wb_rd = 5'd0; wb_reg_wr = 1'b1;
    @(negedge clk);
    check("x0_stall_if", 32'(stall_if), 32'd0);
    check("x0_flush_id", 32'(flush_id), 32'd0);
    check("x0_fwd_a", 32'(fwd_a_sel), 32'd0);
    check("x0_fwd_b", 32'(fwd_b_sel), 32'd0);
    tick();
    idle();

    // Taken branch with a two-cycle flush window.
    ex_valid = 1'b1; br_taken = 1'b1;
    @(negedge clk);
    check("br_c0_flush", {30'd0, flush_if, flush_id}, 32'b11);
    check_stalls("br_c0_stalls", 4'b0000);
    tick();
    idle();
    @(negedge clk);
    check("br_c1_flush", {30'd0, flush_if, flush_id}, 32'b10);
    check("br_c1_state", 32'(dut.state), 32'(FLUSH));
    tick();
    @(negedge clk);
    check("br_c2_flush", {30'd0, flush_if, flush_id}, 32'b00);
    check("br_c2_state", 32'(dut.state), 32'(RUN));
    check("br_flush_cnt", flush_cnt, 32'd2);

    // Three-cycle memory freeze with a branch parked in EX.
    tick();
    mem_req = 1'b1; mem_ready = 1'b0; ex_valid = 1'b1; br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_stalls("frz_stalls", 4'b1111);
      check("frz_flush", {30'd0, flush_if, flush_id}, 32'b00);
      tick();
    end
    check("frz_state", 32'(dut.state), 32'(MEM_WAIT));
    mem_ready = 1'b1;
    @(negedge clk);
    check_stalls("rel_stalls", 4'b0000);
    check("rel_flush", {30'd0, flush_if, flush_id}, 32'b11);
    tick();
    idle();
    @(negedge clk);
    check("rel_flush2", {30'd0, flush_if, flush_id}, 32'b10);
    tick();
    @(negedge clk);
    check("rel_state", 32'(dut.state), 32'(RUN));
    check("frz_stall_cnt", stall_cnt, 32'd4);
    check("frz_flush_cnt", flush_cnt, 32'd4);

    // Forwarding priority: MEM over WB, then WB alone.
    ex_rs1 = 5'd7; ex_rs2 = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
    mem_reg_wr = 1'b1; wb_reg_wr = 1'b1;
    @(negedge clk);
    check("fwd_a_mem", 32'(fwd_a_sel), 32'(FWD_MEM));
    check("fwd_b_mem", 32'(fwd_b_sel), 32'(FWD_MEM));
    mem_reg_wr = 1'b0;
    #1;
    check("fwd_a_wb", 32'(fwd_a_sel), 32'(FWD_WB));
    tick();
    idle();

    // Reset taken from MEM_WAIT.
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    check("pre_rst_state", 32'(dut.state), 32'(MEM_WAIT));
    rst = 1'b1; mem_rd = 5'd7; mem_reg_wr = 1'b1; ex_rs1 = 5'd7;
    @(negedge clk);
    check_stalls("mid_rst_stalls", 4'b0000);
    check("mid_rst_fwd_a", 32'(fwd_a_sel), 32'd0);
    tick();
    check("mid_rst_state", 32'(dut.state), 32'(RUN));
    check("mid_rst_stall_cnt", stall_cnt, 32'd0);
    check("mid_rst_flush_cnt", flush_cnt, 32'd0);
    idle();
    rst = 1'b0;

    // Nine stalled cycles: the 3-bit counter must stop at 7.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("sat_narrow", 32'(n_stall_cnt), 32'd7);
    check("sat_wide", stall_cnt, 32'd9);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
